// File: rtl/cfu_cmd_issuer.sv
// CFU command issuer: queues operand requests, drives them one at a time onto the
// Cfu cmd channel and collects each rsp (or a timeout marker) into a result FIFO.
module cfu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [9:0]  res_function_id,
  output logic        res_timeout,
  output logic        err_timeout,
  output logic        err_stale,
  output logic        busy
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned REQ_W = 74;
  localparam int unsigned RES_W = 43;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP} state_t;

  state_t           state;
  logic [15:0]      to_cnt;

  logic [REQ_W-1:0] req_mem [DEPTH];
  logic [PW-1:0]    req_wr_ptr;
  logic [PW-1:0]    req_rd_ptr;
  logic [CW-1:0]    req_cnt;

  logic [RES_W-1:0] res_mem [DEPTH];
  logic [PW-1:0]    res_wr_ptr;
  logic [PW-1:0]    res_rd_ptr;
  logic [CW-1:0]    res_cnt;

  logic             req_push;
  logic             issue;
  logic             rsp_hit;
  logic             to_hit;
  logic             res_push;
  logic             res_pop;
  logic [REQ_W-1:0] req_head;
  logic [RES_W-1:0] res_entry;

  assign req_ready = req_cnt < CW'(DEPTH);
  assign req_push  = req_valid && req_ready;
  assign req_head  = req_mem[req_rd_ptr];

  // Issue only when the result FIFO can absorb the eventual response.
  assign issue     = (state == S_IDLE) && (req_cnt != '0) && (res_cnt < CW'(DEPTH));
  assign rsp_hit   = (state == S_WAIT_RSP) && rsp_valid;
  assign to_hit    = (state == S_WAIT_RSP) && !rsp_valid && (TIMEOUT != 16'd0) &&
                     (to_cnt == TIMEOUT - 16'd1);
  assign res_push  = rsp_hit || to_hit;
  assign res_entry = rsp_hit ? {1'b0, cmd_payload_function_id, rsp_payload_outputs_0}
                             : {1'b1, cmd_payload_function_id, 32'd0};

  assign res_valid = res_cnt != '0;
  assign res_pop   = res_valid && res_ready;
  assign {res_timeout, res_function_id, res_data} = res_mem[res_rd_ptr];

  // Responses are always accepted so a late rsp can never wedge the Cfu.
  assign rsp_ready = 1'b1;
  assign busy      = (state != S_IDLE) || (req_cnt != '0);

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr] <= {req_function_id, req_inputs_0, req_inputs_1};
    if (res_push) res_mem[res_wr_ptr] <= res_entry;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_cnt    <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_cnt    <= '0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + PW'(1);
      if (issue)    req_rd_ptr <= req_rd_ptr + PW'(1);
      if (req_push && !issue)      req_cnt <= req_cnt + CW'(1);
      else if (!req_push && issue) req_cnt <= req_cnt - CW'(1);

      if (res_push) res_wr_ptr <= res_wr_ptr + PW'(1);
      if (res_pop)  res_rd_ptr <= res_rd_ptr + PW'(1);
      if (res_push && !res_pop)      res_cnt <= res_cnt + CW'(1);
      else if (!res_push && res_pop) res_cnt <= res_cnt - CW'(1);
    end
  end

  // Command sequencing, timeout counting and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= S_IDLE;
      cmd_valid               <= 1'b0;
      cmd_payload_function_id <= '0;
      cmd_payload_inputs_0    <= '0;
      cmd_payload_inputs_1    <= '0;
      to_cnt                  <= '0;
      err_timeout             <= 1'b0;
      err_stale               <= 1'b0;
    end else begin
      if (rsp_valid && (state != S_WAIT_RSP)) err_stale <= 1'b1;
      case (state)
        S_IDLE: begin
          if (issue) begin
            {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} <= req_head;
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            to_cnt    <= '0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            state <= S_IDLE;
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Bench for cfu_cmd_issuer: a Cfu responder model plus an in-order result
// scoreboard derived from the request stream.
module tb_cfu_cmd_issuer;

  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] TIMEOUT = 16'd8;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_function_id;
  logic [31:0] req_inputs_0;
  logic [31:0] req_inputs_1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [9:0]  res_function_id;
  logic        res_timeout;
  logic        err_timeout;
  logic        err_stale;
  logic        busy;

  cfu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
    .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_function_id(res_function_id), .res_timeout(res_timeout),
    .err_timeout(err_timeout), .err_stale(err_stale), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [73:0] reqq[$];
  logic [42:0] exp_q[$];
  logic [42:0] got[$];
  int          got_lat[$];
  logic [73:0] cmd_log[$];

  int stepn, cfu_lat, stall_max, stall_left, pend_cnt;
  int unstable, drops, cv_cycles, hs_step, first_cmd_step, req_hs_step;
  bit lat_rand, stall_rand, rsp_plus1, res_rdy_en, res_rand, inject_stale, stale_ready_seen;
  bit pending, in_cmd, prev_cv, prev_hs, saw_full;
  logic [31:0] pend_in0;
  logic [73:0] cap;

  task automatic clear_bench();
    reqq.delete(); exp_q.delete(); got.delete(); got_lat.delete(); cmd_log.delete();
    stepn = 0; cfu_lat = 0; stall_max = 0; stall_left = 0; pend_cnt = 0;
    unstable = 0; drops = 0; cv_cycles = 0; hs_step = 0; first_cmd_step = -1; req_hs_step = -1;
    lat_rand = 0; stall_rand = 0; rsp_plus1 = 0; res_rdy_en = 1; res_rand = 0;
    inject_stale = 0; stale_ready_seen = 0;
    pending = 0; in_cmd = 0; prev_cv = 0; prev_hs = 0; saw_full = 0;
    pend_in0 = '0; cap = '0;
    req_valid = 0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_payload_outputs_0 = '0; res_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected result follows directly from the request and the Cfu behaviour chosen.
  task automatic add_req(input logic [9:0] fid, input logic [31:0] in0,
                         input logic [31:0] in1, input bit tmo);
    reqq.push_back({fid, in0, in1});
    if (tmo) exp_q.push_back({1'b1, fid, 32'd0});
    else     exp_q.push_back({1'b0, fid, rsp_plus1 ? in0 + 32'd1 : 32'd0});
  endtask

  // One clock: sample outputs at negedge, then drive inputs for the next posedge.
  task automatic step();
    @(negedge clk);
    stepn++;
    res_ready = res_rand ? 1'($urandom_range(0, 1)) : res_rdy_en;
    if (res_valid && res_ready) begin
      got.push_back({res_timeout, res_function_id, res_data});
      got_lat.push_back(stepn - hs_step);
    end
    rsp_valid = 1'b0;
    rsp_payload_outputs_0 = '0;
    if (inject_stale) begin
      rsp_valid = 1'b1;
      rsp_payload_outputs_0 = $urandom;
      stale_ready_seen = rsp_ready;
      inject_stale = 0;
    end else if (pending && pend_cnt >= 0) begin
      if (pend_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_payload_outputs_0 = rsp_plus1 ? pend_in0 + 32'd1 : 32'd0;
        pending = 0;
      end else begin
        pend_cnt--;
      end
    end
    if (reqq.size() != 0) begin
      req_valid = 1'b1;
      {req_function_id, req_inputs_0, req_inputs_1} = reqq[0];
      if (req_ready) begin
        if (req_hs_step < 0) req_hs_step = stepn;
        void'(reqq.pop_front());
      end else begin
        saw_full = 1;
      end
    end else begin
      req_valid = 1'b0;
    end
    if (prev_cv && !prev_hs && !cmd_valid) drops++;
    cmd_ready = 1'b0;
    if (cmd_valid) begin
      cv_cycles++;
      if (first_cmd_step < 0) first_cmd_step = stepn;
      if (!in_cmd) begin
        in_cmd = 1;
        cap = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
        stall_left = stall_rand ? int'($urandom_range(0, 3)) : stall_max;
      end else if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== cap) begin
        unstable++;
      end
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        cmd_ready = 1'b1;
        in_cmd = 0;
        cmd_log.push_back(cap);
        pending = 1;
        pend_cnt = lat_rand ? int'($urandom_range(0, 3)) : cfu_lat;
        pend_in0 = cap[63:32];
        hs_step = stepn;
      end
    end
    prev_cv = cmd_valid;
    prev_hs = cmd_valid && cmd_ready;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== 74'd0) begin
      errors++; $display("FAIL reset_payload got %h exp 0", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}); end
    checks++; if ({rsp_ready, req_ready} !== 2'b11) begin errors++; $display("FAIL reset_readies got %b exp 11", {rsp_ready, req_ready}); end
    checks++; if ({res_valid, err_timeout, err_stale, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {res_valid, err_timeout, err_stale, busy}); end
  endtask

  task automatic test_single_load();
    int cyc;
    do_reset();
    cfu_lat = 0;
    add_req(10'h008, 32'd5, 32'hA5A5A5A5, 0);
    cyc = 0;
    while (got.size() < 1 && cyc < 40) begin step(); cyc++; end
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got.size()); end
    if (cmd_log.size() > 0) begin
      checks++; if (cmd_log[0] !== {10'h008, 32'd5, 32'hA5A5A5A5}) begin
        errors++; $display("FAIL single_cmd_payload got %h exp %h", cmd_log[0], {10'h008, 32'd5, 32'hA5A5A5A5}); end
    end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL single_result got %h exp %h", got[0], exp_q[0]); end
      checks++; if (got_lat[0] !== 2) begin errors++; $display("FAIL single_rsp_to_res got %0d exp 2", got_lat[0]); end
    end
    checks++; if (first_cmd_step - req_hs_step !== 2) begin
      errors++; $display("FAIL single_req_to_cmd got %0d exp 2", first_cmd_step - req_hs_step); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    rsp_plus1 = 1; cfu_lat = 1; stall_max = 3;
    for (int i = 0; i < 4; i++) add_req(10'($urandom), 32'(10 + i), $urandom, 0);
    cyc = 0;
    while (got.size() < 4 && cyc < 200) begin step(); cyc++; end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      checks++; if (got_lat[i] !== 3) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp 3", i, got_lat[i]); end
    end
    checks++; if (cv_cycles !== 16) begin errors++; $display("FAIL b2b_cmd_valid_cycles got %0d exp 16", cv_cycles); end
    checks++; if (unstable !== 0 || drops !== 0) begin
      errors++; $display("FAIL b2b_cmd_stable got unstable=%0d drops=%0d exp 0/0", unstable, drops); end
  endtask

  task automatic test_full();
    int cyc;
    do_reset();
    rsp_plus1 = 1; cfu_lat = 5; res_rdy_en = 0;
    for (int i = 0; i < 6; i++) add_req(10'($urandom), $urandom, $urandom, 0);
    repeat (120) step();
    checks++; if (cmd_log.size() !== 4) begin errors++; $display("FAIL full_issued got %0d exp 4", cmd_log.size()); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL full_popped got %0d exp 0", got.size()); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL full_req_ready_drop got %b exp 1", saw_full); end
    checks++; if ({res_valid, req_ready, busy} !== 3'b111) begin
      errors++; $display("FAIL full_status got %b exp 111", {res_valid, req_ready, busy}); end
    res_rdy_en = 1;
    cyc = 0;
    while (got.size() < 6 && cyc < 200) begin step(); cyc++; end
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL full_drain_count got %0d exp 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_result[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    cfu_lat = -1;
    for (int i = 0; i < 2; i++) add_req(10'($urandom), $urandom, $urandom, 1);
    cyc = 0;
    while (got.size() < 2 && cyc < 100) begin step(); cyc++; end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL timeout_count got %0d exp 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_result[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      checks++; if (got_lat[i] !== int'(TIMEOUT) + 1) begin
        errors++; $display("FAIL timeout_latency[%0d] got %0d exp %0d", i, got_lat[i], int'(TIMEOUT) + 1); end
    end
    checks++; if ({err_timeout, err_stale} !== 2'b10) begin
      errors++; $display("FAIL timeout_flags got %b exp 10", {err_timeout, err_stale}); end
  endtask

  // Continues from test_timeout: the FSM is idle when the late rsp arrives.
  task automatic test_stale_rsp();
    repeat (2) step();
    inject_stale = 1;
    repeat (4) step();
    checks++; if (stale_ready_seen !== 1'b1) begin errors++; $display("FAIL stale_rsp_ready got %b exp 1", stale_ready_seen); end
    checks++; if (got.size() !== 2 || res_valid !== 1'b0) begin
      errors++; $display("FAIL stale_no_entry got count=%0d res_valid=%b exp 2/0", got.size(), res_valid); end
    checks++; if ({err_timeout, err_stale} !== 2'b11) begin
      errors++; $display("FAIL stale_flags got %b exp 11", {err_timeout, err_stale}); end
  endtask

  task automatic test_random();
    int cyc;
    do_reset();
    rsp_plus1 = 1; lat_rand = 1; stall_rand = 1; res_rand = 1;
    for (int i = 0; i < 12; i++) add_req(10'($urandom), $urandom, $urandom, 0);
    cyc = 0;
    while (got.size() < 12 && cyc < 600) begin step(); cyc++; end
    checks++; if (got.size() !== 12) begin errors++; $display("FAIL random_count got %0d exp 12", got.size()); end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL random_result[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    checks++; if (unstable !== 0 || drops !== 0) begin
      errors++; $display("FAIL random_cmd_stable got unstable=%0d drops=%0d exp 0/0", unstable, drops); end
  endtask

  task automatic test_reset_midop();
    int cyc;
    do_reset();
    cfu_lat = -1;
    for (int i = 0; i < 3; i++) add_req(10'($urandom), $urandom, $urandom, 1);
    cyc = 0;
    while (!(cmd_log.size() == 1 && reqq.size() == 0) && cyc < 30) begin step(); cyc++; end
    repeat (2) step();
    checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL midop_pre_reset got busy=%b cmd_valid=%b exp 1/0", busy, cmd_valid); end
    #1 reset = 1'b1;
    clear_bench();
    #1;
    checks++; if ({cmd_valid, res_valid, req_ready, busy} !== 4'b0010) begin
      errors++; $display("FAIL midop_reset_state got %b exp 0010", {cmd_valid, res_valid, req_ready, busy}); end
    @(negedge clk);
    reset = 1'b0;
    inject_stale = 1;
    repeat (3) step();
    checks++; if ({err_stale, err_timeout, res_valid} !== 3'b100) begin
      errors++; $display("FAIL midop_late_rsp got %b exp 100", {err_stale, err_timeout, res_valid}); end
  endtask

  initial begin
    reset = 1'b1;
    clear_bench();
    test_reset();
    test_single_load();
    test_back_to_back();
    test_full();
    test_timeout();
    test_stale_rsp();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
